// File: rtl/branch_predictor.sv
// Branch predictor with a 16-entry direct-mapped table.
// Each entry holds a 12-bit tag, a 2-bit saturating counter and a 16-bit target.
// Lookup is combinational from fetch_pc. Mispredict detection is combinational
// from the branch resolving in EX. The table updates and the stats pulses are
// registered.
module branch_predictor (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fetch_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [15:0] pred_tgt,
  input  logic        ex_br_vld,
  input  logic [15:0] ex_pc,
  input  logic        ex_taken,
  input  logic [15:0] ex_tgt,
  input  logic        ex_pred_taken,
  input  logic [15:0] ex_pred_tgt,
  output logic        flush,
  output logic [15:0] redirect_pc,
  output logic        inc_br_cnt,
  output logic        inc_hit_cnt,
  output logic        inc_mispr_cnt
);

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;

  logic        valid_r [16];
  logic [11:0] tag_r   [16];
  logic [1:0]  ctr_r   [16];
  logic [15:0] tgt_r   [16];

  logic [3:0]  fetch_idx_s;
  logic [3:0]  ex_idx_s;
  logic        ex_hit_s;
  logic        mispredict_s;

  // Saturating increment of a 2-bit counter (11 stays 11).
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b10;
      2'b10:   r = 2'b11;
      2'b11:   r = 2'b11;
      default: r = 2'b11;
    endcase
    return r;
  endfunction

  // Saturating decrement of a 2-bit counter (00 stays 00).
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      2'b00:   r = 2'b00;
      2'b01:   r = 2'b00;
      2'b10:   r = 2'b01;
      2'b11:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Fetch-side lookup against the current (pre-update) table contents.
  always_comb begin
    fetch_idx_s = fetch_pc[3:0];
    pred_hit    = valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_pc[15:4]);
    pred_taken  = pred_hit && ctr_r[fetch_idx_s][1];
    if (pred_hit) begin
      pred_tgt = tgt_r[fetch_idx_s];
    end else begin
      pred_tgt = fetch_pc + 16'd1;
    end
  end

  // Look up the EX branch in the table and decide whether it was mispredicted.
  always_comb begin
    ex_idx_s = ex_pc[3:0];
    ex_hit_s = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_pc[15:4]);
    if (!ex_br_vld) begin
      mispredict_s = 1'b0;
    end else if (ex_taken != ex_pred_taken) begin
      mispredict_s = 1'b1;
    end else if (ex_taken && (ex_tgt != ex_pred_tgt)) begin
      mispredict_s = 1'b1;
    end else begin
      mispredict_s = 1'b0;
    end
    flush = mispredict_s;
    if (ex_taken) begin
      redirect_pc = ex_tgt;
    end else begin
      redirect_pc = ex_pc + 16'd1;
    end
  end

  // Table update from the resolving branch. Reset overrides any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        valid_r[i] <= 1'b0;
        tag_r[i]   <= 12'h000;
        ctr_r[i]   <= CTR_WEAK_NT;
        tgt_r[i]   <= 16'h0000;
      end
    end else if (ex_br_vld) begin
      if (ex_hit_s) begin
        if (ex_taken) begin
          ctr_r[ex_idx_s] <= sat_inc(ctr_r[ex_idx_s]);
          tgt_r[ex_idx_s] <= ex_tgt;
        end else begin
          ctr_r[ex_idx_s] <= sat_dec(ctr_r[ex_idx_s]);
        end
      end else if (ex_taken) begin
        valid_r[ex_idx_s] <= 1'b1;
        tag_r[ex_idx_s]   <= ex_pc[15:4];
        ctr_r[ex_idx_s]   <= CTR_WEAK_T;
        tgt_r[ex_idx_s]   <= ex_tgt;
      end
    end
  end

  // One-cycle stats pulses for each resolved branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_br_cnt    <= 1'b0;
      inc_hit_cnt   <= 1'b0;
      inc_mispr_cnt <= 1'b0;
    end else begin
      inc_br_cnt    <= ex_br_vld;
      inc_hit_cnt   <= ex_br_vld && !mispredict_s;
      inc_mispr_cnt <= mispredict_s;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. A behavioural table model is
// built from integer counters and arrays, and it is advanced on every clock edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_pc;
  logic        pred_hit, pred_taken;
  logic [15:0] pred_tgt;
  logic        ex_br_vld, ex_taken, ex_pred_taken;
  logic [15:0] ex_pc, ex_tgt, ex_pred_tgt;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        inc_br_cnt, inc_hit_cnt, inc_mispr_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  bit mdl_valid [16];
  int mdl_tag   [16];
  int mdl_ctr   [16];
  int mdl_tgt   [16];
  bit exp_br, exp_hit, exp_mis;

  branch_predictor dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_tgt(pred_tgt),
    .ex_br_vld(ex_br_vld), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_tgt(ex_tgt),
    .ex_pred_taken(ex_pred_taken), .ex_pred_tgt(ex_pred_tgt),
    .flush(flush), .redirect_pc(redirect_pc),
    .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt), .inc_mispr_cnt(inc_mispr_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_hit(input logic [15:0] pc);
    int idx = int'(pc) % 16;
    return mdl_valid[idx] && (mdl_tag[idx] == int'(pc) / 16);
  endfunction

  function automatic bit m_taken(input logic [15:0] pc);
    return m_hit(pc) && (mdl_ctr[int'(pc) % 16] >= 2);
  endfunction

  function automatic logic [15:0] m_tgt(input logic [15:0] pc);
    int t;
    if (m_hit(pc)) t = mdl_tgt[int'(pc) % 16];
    else t = (int'(pc) + 1) % 65536;
    return 16'(t);
  endfunction

  function automatic bit m_mispr();
    if (!ex_br_vld) return 1'b0;
    if (ex_taken != ex_pred_taken) return 1'b1;
    if (ex_taken && ex_pred_taken && (ex_tgt != ex_pred_tgt)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_redirect();
    if (ex_taken) return ex_tgt;
    return 16'((int'(ex_pc) + 1) % 65536);
  endfunction

  // Advance one clock edge. The model takes the inputs as they were at the edge.
  task automatic tick();
    int idx;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mdl_valid[i] = 1'b0; mdl_tag[i] = 0; mdl_ctr[i] = 1; mdl_tgt[i] = 0;
      end
      exp_br = 1'b0; exp_hit = 1'b0; exp_mis = 1'b0;
    end else begin
      exp_br  = ex_br_vld;
      exp_mis = m_mispr();
      exp_hit = ex_br_vld && !exp_mis;
      if (ex_br_vld) begin
        idx = int'(ex_pc) % 16;
        if (m_hit(ex_pc)) begin
          if (ex_taken) begin
            mdl_ctr[idx] = (mdl_ctr[idx] == 3) ? 3 : mdl_ctr[idx] + 1;
            mdl_tgt[idx] = int'(ex_tgt);
          end else begin
            mdl_ctr[idx] = (mdl_ctr[idx] == 0) ? 0 : mdl_ctr[idx] - 1;
          end
        end else if (ex_taken) begin
          mdl_valid[idx] = 1'b1;
          mdl_tag[idx]   = int'(ex_pc) / 16;
          mdl_ctr[idx]   = 2;
          mdl_tgt[idx]   = int'(ex_tgt);
        end
      end
    end
    #1;
  endtask

  task automatic drive_ex(input bit vld, input logic [15:0] pc, input bit tk,
                          input logic [15:0] tgt, input bit ptk, input logic [15:0] ptgt);
    ex_br_vld = vld; ex_pc = pc; ex_taken = tk; ex_tgt = tgt;
    ex_pred_taken = ptk; ex_pred_tgt = ptgt;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_pc = 16'h0000;
    drive_ex(1'b1, 16'h0012, 1'b1, 16'h0040, 1'b0, 16'h0000);
    tick(); tick();
    rst = 1'b0;
    drive_ex(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
    fetch_pc = 16'h0010; #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_tgt !== 16'h0011) begin
      failures++;
      $display("FAIL reset_lookup: got hit=%b tk=%b tgt=%h, want 0 0 0011", pred_hit, pred_taken, pred_tgt);
    end
    checks++;
    if ({inc_br_cnt, inc_hit_cnt, inc_mispr_cnt} !== 3'b000) begin
      failures++;
      $display("FAIL reset_inc: got %b%b%b, want 000", inc_br_cnt, inc_hit_cnt, inc_mispr_cnt);
    end
    fetch_pc = 16'hFFFF; #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_tgt !== 16'h0000) begin
      failures++;
      $display("FAIL fetch_wrap: got hit=%b tgt=%h, want 0 0000", pred_hit, pred_tgt);
    end
  endtask

  task automatic test_cold_taken();
    fetch_pc = 16'h0012;
    drive_ex(1'b1, 16'h0012, 1'b1, 16'h0040, 1'b0, 16'h0000);
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 16'h0040) begin
      failures++;
      $display("FAIL cold_flush: got flush=%b redir=%h, want 1 0040", flush, redirect_pc);
    end
    tick();
    drive_ex(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
    checks++;
    if (inc_br_cnt !== 1'b1 || inc_mispr_cnt !== 1'b1 || inc_hit_cnt !== 1'b0) begin
      failures++;
      $display("FAIL cold_inc: got br=%b hit=%b mis=%b, want 1 0 1", inc_br_cnt, inc_hit_cnt, inc_mispr_cnt);
    end
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_tgt !== 16'h0040) begin
      failures++;
      $display("FAIL cold_lookup: got hit=%b tk=%b tgt=%h, want 1 1 0040", pred_hit, pred_taken, pred_tgt);
    end
  endtask

  task automatic test_hysteresis();
    fetch_pc = 16'h0012;
    repeat (2) begin
      drive_ex(1'b1, 16'h0012, 1'b1, 16'h0040, 1'b1, 16'h0040);
      tick();
    end
    drive_ex(1'b1, 16'h0012, 1'b0, 16'h0000, 1'b1, 16'h0040);
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 16'h0013) begin
      failures++;
      $display("FAIL nt_flush: got flush=%b redir=%h, want 1 0013", flush, redirect_pc);
    end
    tick();
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL hyst_first_nt: got hit=%b tk=%b, want 1 1", pred_hit, pred_taken);
    end
    drive_ex(1'b1, 16'h0012, 1'b0, 16'h0000, 1'b1, 16'h0040);
    tick();
    drive_ex(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_tgt !== 16'h0040) begin
      failures++;
      $display("FAIL hyst_second_nt: got hit=%b tk=%b tgt=%h, want 1 0 0040", pred_hit, pred_taken, pred_tgt);
    end
  endtask

  task automatic test_alias();
    fetch_pc = 16'h0012;
    drive_ex(1'b1, 16'h0022, 1'b1, 16'h0050, 1'b1, 16'h0051);
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 16'h0050) begin
      failures++;
      $display("FAIL tgt_mismatch: got flush=%b redir=%h, want 1 0050", flush, redirect_pc);
    end
    tick();
    drive_ex(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
    checks++;
    if (pred_hit !== 1'b0) begin
      failures++;
      $display("FAIL alias_evict: got hit=%b, want 0", pred_hit);
    end
    fetch_pc = 16'h0022; #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_tgt !== 16'h0050) begin
      failures++;
      $display("FAIL alias_alloc: got hit=%b tk=%b tgt=%h, want 1 1 0050", pred_hit, pred_taken, pred_tgt);
    end
    drive_ex(1'b1, 16'hFFFF, 1'b0, 16'h1234, 1'b1, 16'h1234);
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 16'h0000) begin
      failures++;
      $display("FAIL redirect_wrap: got flush=%b redir=%h, want 1 0000", flush, redirect_pc);
    end
    drive_ex(1'b1, 16'h0022, 1'b1, 16'h0050, 1'b1, 16'h0050);
    checks++;
    if (flush !== 1'b0) begin
      failures++;
      $display("FAIL correct_pred: got flush=%b, want 0", flush);
    end
    tick();
    checks++;
    if (inc_hit_cnt !== 1'b1 || inc_mispr_cnt !== 1'b0) begin
      failures++;
      $display("FAIL hit_inc: got hit=%b mis=%b, want 1 0", inc_hit_cnt, inc_mispr_cnt);
    end
  endtask

  task automatic test_collision();
    fetch_pc = 16'h0012;
    drive_ex(1'b1, 16'h0012, 1'b1, 16'h0077, 1'b0, 16'h0000);
    checks++;
    if (pred_hit !== 1'b0) begin
      failures++;
      $display("FAIL collision_same: got hit=%b, want 0", pred_hit);
    end
    tick();
    drive_ex(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
    checks++;
    if (pred_hit !== 1'b1 || pred_tgt !== 16'h0077) begin
      failures++;
      $display("FAIL collision_next: got hit=%b tgt=%h, want 1 0077", pred_hit, pred_tgt);
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    drive_ex(1'b1, 16'h0013, 1'b1, 16'h0099, 1'b0, 16'h0000);
    tick();
    rst = 1'b0;
    drive_ex(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
    checks++;
    if ({inc_br_cnt, inc_hit_cnt, inc_mispr_cnt} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid_inc: got %b%b%b, want 000", inc_br_cnt, inc_hit_cnt, inc_mispr_cnt);
    end
    foreach (mdl_valid[i]) begin
      fetch_pc = 16'(16'h0010 + i); #1;
      checks++;
      if (pred_hit !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_lookup: pc=%h got hit=%b, want 0", fetch_pc, pred_hit);
      end
    end
    fetch_pc = 16'h0022; #1;
    checks++;
    if (pred_hit !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_alias: got hit=%b, want 0", pred_hit);
    end
  endtask

  function automatic logic [15:0] pick_pc();
    if ($urandom_range(0, 15) == 0) return 16'hFFFF;
    return 16'(($urandom_range(0, 2) * 16) + $urandom_range(0, 3));
  endfunction

  task automatic test_back_to_back_random();
    int n_br = 0, n_hit = 0, n_mis = 0;
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom_range(0, 40) == 0);
      fetch_pc = pick_pc();
      ex_br_vld = ($urandom_range(0, 3) != 0);
      ex_pc = pick_pc();
      ex_taken = 1'($urandom_range(0, 1));
      ex_tgt = ($urandom_range(0, 1) == 1) ? 16'h0040 : 16'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        ex_pred_taken = m_taken(ex_pc);
        ex_pred_tgt = m_tgt(ex_pc);
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1));
        ex_pred_tgt = 16'($urandom);
      end
      #1;
      checks++;
      if (pred_hit !== m_hit(fetch_pc) || pred_taken !== m_taken(fetch_pc) || pred_tgt !== m_tgt(fetch_pc)) begin
        failures++;
        $display("FAIL rnd_lookup: pc=%h got %b %b %h, want %b %b %h", fetch_pc,
                 pred_hit, pred_taken, pred_tgt, m_hit(fetch_pc), m_taken(fetch_pc), m_tgt(fetch_pc));
      end
      checks++;
      if (flush !== m_mispr() || (m_mispr() && redirect_pc !== m_redirect())) begin
        failures++;
        $display("FAIL rnd_flush: got flush=%b redir=%h, want %b %h", flush, redirect_pc, m_mispr(), m_redirect());
      end
      tick();
      checks++;
      if (inc_br_cnt !== exp_br || inc_hit_cnt !== exp_hit || inc_mispr_cnt !== exp_mis) begin
        failures++;
        $display("FAIL rnd_inc: got %b%b%b, want %b%b%b", inc_br_cnt, inc_hit_cnt, inc_mispr_cnt,
                 exp_br, exp_hit, exp_mis);
      end
      n_br += int'(inc_br_cnt); n_hit += int'(inc_hit_cnt); n_mis += int'(inc_mispr_cnt);
    end
    rst = 1'b0;
    checks++;
    if (n_br != n_hit + n_mis || n_br == 0) begin
      failures++;
      $display("FAIL rnd_count_balance: br=%0d hit=%0d mis=%0d", n_br, n_hit, n_mis);
    end
  endtask

  initial begin
    test_reset();
    test_cold_taken();
    test_hysteresis();
    test_alias();
    test_collision();
    test_reset_midstream();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset; sampled only at posedge clk.
REQ-003 SHALL have port fetch_pc, input, 16 bits: PC being fetched this cycle.
REQ-004 SHALL have port pred_hit, output, 1 bit: table entry valid and tag matches fetch_pc.
REQ-005 SHALL have port pred_taken, output, 1 bit: predict taken for fetch_pc.
REQ-006 SHALL have port pred_tgt, output, 16 bits: predicted target for fetch_pc.
REQ-007 SHALL have port ex_br_vld, input, 1 bit: a branch resolves in EX this cycle.
REQ-008 SHALL have port ex_pc, input, 16 bits: PC of the resolving branch.
REQ-009 SHALL have port ex_taken, input, 1 bit: actual branch outcome.
REQ-010 SHALL have port ex_tgt, input, 16 bits: actual taken target.
REQ-011 SHALL have port ex_pred_taken, input, 1 bit: prediction carried down the pipe with the branch.
REQ-012 SHALL have port ex_pred_tgt, input, 16 bits: predicted target carried down the pipe.
REQ-013 SHALL have port flush, output, 1 bit: mispredict; flush younger instructions.
REQ-014 SHALL have port redirect_pc, output, 16 bits: correct fetch PC when flush=1.
REQ-015 SHALL have ports inc_br_cnt, inc_hit_cnt and inc_mispr_cnt, output, 1 bit each: single-cycle pulses to the stats counter block.

Function
REQ-016 SHALL hold 16 entries, each {valid, tag[11:0], ctr[1:0], tgt[15:0]}; index=pc[3:0], tag=pc[15:4].
REQ-017 SHALL compute the lookup combinationally from fetch_pc and current table state: pred_hit=valid&&tag match; pred_taken=pred_hit&&ctr[1]; pred_tgt=entry tgt when pred_hit, else fetch_pc+1 (16-bit wrap: 0xFFFF+1=0x0000).
REQ-018 SHALL encode ctr as 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-019 SHALL, when ex_br_vld and the ex_pc entry hits, update at the next posedge: taken: ctr saturating +1 (11 stays 11) and tgt<=ex_tgt; not-taken: ctr saturating -1 (00 stays 00), tgt unchanged.
REQ-020 SHALL, when ex_br_vld and the entry misses and ex_taken=1, allocate by overwriting the indexed entry: valid=1, tag=ex_pc[15:4], ctr=10, tgt=ex_tgt; miss and ex_taken=0 SHALL leave the entry unchanged.
REQ-021 SHALL define mispredict = ex_br_vld && ((ex_taken!=ex_pred_taken) || (ex_taken && ex_pred_taken && ex_tgt!=ex_pred_tgt)).
REQ-022 SHALL drive flush=mispredict combinationally, same cycle; redirect_pc=ex_taken ? ex_tgt : ex_pc+1 (wraps); redirect_pc don't-care when flush=0.
REQ-023 SHALL register inc_br_cnt<=ex_br_vld, inc_mispr_cnt<=mispredict, inc_hit_cnt<=ex_br_vld&&!mispredict: 1-cycle latency, high for exactly one cycle per resolved branch.
REQ-024 SHALL keep inc_hit_cnt and inc_mispr_cnt mutually exclusive; each SHALL imply inc_br_cnt in the same cycle.
REQ-025 SHALL, when fetch and update hit the same index in one cycle, return pre-update entry contents to the fetch (no bypass).
REQ-026 SHALL accept back-to-back ex_br_vld every cycle; each update uses the state left by the previous one.
REQ-027 SHALL NOT apply updates gated by stats enable; stats gating is owned downstream.

Reset
REQ-028 SHALL, while rst=1 at posedge, clear all valid bits, set all ctr=01, tgt=0x0000, tag=0x000, and set inc_br_cnt, inc_hit_cnt and inc_mispr_cnt to 0.
REQ-029 SHALL give rst priority over a coincident ex_br_vld: no table update and no stats pulse from that cycle.
REQ-030 SHALL output pred_hit=0, pred_taken=0, pred_tgt=fetch_pc+1 the cycle after reset.

Verification
REQ-031 SHALL cover post-reset lookup: fetch_pc=0x0010 -> pred_hit=0, pred_taken=0, pred_tgt=0x0011; all inc_* pulses 0.
REQ-032 SHALL cover cold taken: ex_pc=0x0012, ex_taken=1, ex_tgt=0x0040, ex_pred_taken=0 -> flush=1, redirect_pc=0x0040 same cycle; next cycle inc_br_cnt=1, inc_mispr_cnt=1; then fetch_pc=0x0012 -> pred_hit=1, pred_taken=1, pred_tgt=0x0040.
REQ-033 SHALL cover hysteresis: 2 more taken resolves of 0x0012 (ctr=11), then 1 not-taken -> still pred_taken=1; 2nd not-taken -> pred_taken=0, pred_hit=1.
REQ-034 SHALL cover alias and target mismatch: taken ex_pc=0x0022, ex_tgt=0x0050 -> fetch 0x0012 gives pred_hit=0; ex_pred_taken=1, ex_pred_tgt=0x0051 -> flush=1, redirect_pc=0x0050.
REQ-035 SHALL cover same-cycle collision: fetch_pc=ex_pc=0x0012 with allocating update -> pred_hit=0 that cycle, pred_hit=1 next cycle.
REQ-036 SHALL cover reset mid-stream: rst=1 with ex_br_vld=1 -> no inc_* pulse next cycle, all lookups miss; and over random streams, count(inc_br_cnt)=count(inc_hit_cnt)+count(inc_mispr_cnt).
